// File: rtl/rmst_to_fifo_tile_mc_if.sv
// Bundle between the tile loader, the external read master and the FIFO bank.
// The master modport is the loader's view; slave is the view of everything around it.
interface rmst_to_fifo_tile_mc_if #(
  parameter int AW  = 12,
  parameter int XAW = 32,
  parameter int DW  = 32,
  parameter int XDW = 128,
  parameter int CH  = 4
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic           load_data_start;
  logic           load_data_done;
  logic [XAW-1:0] param_raddr;
  logic [AW-1:0]  param_iolen;
  logic           param_mode;
  logic [CHW-1:0] param_ch;

  logic           rmst_fixed_location;
  logic [XAW-1:0] rmst_read_base;
  logic [XAW-1:0] rmst_read_length;
  logic           rmst_go;
  logic           rmst_done;
  logic           rmst_user_read_buffer;
  logic [XDW-1:0] rmst_user_buffer_data;
  logic           rmst_user_data_available;

  logic [DW-1:0]  rmst_data_in;
  logic [CH-1:0]  fifo_push;
  logic [CH-1:0]  fifo_almost_full;

  modport master (
    input  load_data_start, param_raddr, param_iolen, param_mode, param_ch,
    input  rmst_done, rmst_user_buffer_data, rmst_user_data_available, fifo_almost_full,
    output load_data_done, rmst_fixed_location, rmst_read_base, rmst_read_length, rmst_go,
    output rmst_user_read_buffer, rmst_data_in, fifo_push
  );

  modport slave (
    output load_data_start, param_raddr, param_iolen, param_mode, param_ch,
    output rmst_done, rmst_user_buffer_data, rmst_user_data_available, fifo_almost_full,
    input  load_data_done, rmst_fixed_location, rmst_read_base, rmst_read_length, rmst_go,
    input  rmst_user_read_buffer, rmst_data_in, fifo_push
  );
endinterface

// File: rtl/rmst_to_fifo_tile_mc.sv
// Streams a job from an external read master into CH FIFOs, one DW word per cycle,
// splitting the job into tiles of at most TILE_XW wide words.
module rmst_to_fifo_tile_mc #(
  parameter int AW      = 12,
  parameter int XAW     = 32,
  parameter int DW      = 32,
  parameter int XDW     = 128,
  parameter int CH      = 4,
  parameter int TILE_XW = 8
) (
  input logic                   clk,
  input logic                   rst,
  rmst_to_fifo_tile_mc_if.master bus
);
  localparam int WCNT = XDW / DW;
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int LW   = (WCNT > 1) ? $clog2(WCNT) : 1;
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0]  TILE_CAP   = CW'(TILE_XW * WCNT);
  localparam logic [XAW-1:0] WORD_BYTES = XAW'(DW / 8);

  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, WAIT_DONE, FINISH} state_t;

  state_t         state;
  logic [XAW-1:0] addr;
  logic [CW-1:0]  remaining;
  logic [CW-1:0]  push_rem;
  logic           mode;
  logic [CHW-1:0] ch_sel;
  logic [CHW-1:0] ch_ptr;
  logic [XDW-1:0] hold;
  logic           hold_valid;
  logic [LW-1:0]  lane;
  logic           done_seen;
  logic [XAW-1:0] read_base;
  logic [XAW-1:0] read_length;
  logic           go;
  logic           load_done;

  logic [CHW-1:0] target;
  logic [CW-1:0]  tile;
  logic [CW-1:0]  held;
  logic           last_lane;
  logic           push;
  logic           pop;

  assign target    = mode ? ch_sel : ch_ptr;
  assign tile      = (remaining < TILE_CAP) ? remaining : TILE_CAP;
  assign held      = hold_valid ? (CW'(WCNT) - CW'(lane)) : '0;
  assign last_lane = (lane == LW'(WCNT - 1));

  // A pop refills the holding register in the same cycle its last lane leaves, and
  // never fetches beyond the words still owed for this tile.
  assign push = (state == STREAM) && hold_valid && !bus.fifo_almost_full[target];
  assign pop  = (state == STREAM) && bus.rmst_user_data_available && (push_rem > held) &&
                (!hold_valid || (push && last_lane));

  assign bus.rmst_user_read_buffer = pop;
  assign bus.fifo_push             = push ? (CH'(1) << target) : '0;
  assign bus.rmst_data_in          = push ? hold[int'(lane)*DW +: DW] : '0;
  assign bus.rmst_fixed_location   = 1'b0;
  assign bus.rmst_go               = go;
  assign bus.rmst_read_base        = read_base;
  assign bus.rmst_read_length      = read_length;
  assign bus.load_data_done        = load_done;

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      push_rem    <= '0;
      mode        <= 1'b0;
      ch_sel      <= '0;
      ch_ptr      <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      lane        <= '0;
      done_seen   <= 1'b0;
      read_base   <= '0;
      read_length <= '0;
      go          <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      go        <= 1'b0;
      load_done <= 1'b0;

      if (pop) begin
        hold       <= bus.rmst_user_buffer_data;
        hold_valid <= 1'b1;
        lane       <= '0;
      end else if (push) begin
        if (last_lane) begin
          hold_valid <= 1'b0;
          lane       <= '0;
        end else begin
          lane <= lane + 1'b1;
        end
      end

      if (push) begin
        ch_ptr   <= (ch_ptr == CHW'(CH - 1)) ? '0 : ch_ptr + 1'b1;
        push_rem <= push_rem - 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.load_data_start) begin
            addr      <= bus.param_raddr;
            remaining <= CW'(bus.param_iolen);
            mode      <= bus.param_mode;
            ch_sel    <= bus.param_ch;
            ch_ptr    <= '0;
            state     <= (bus.param_iolen == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          read_base   <= addr;
          read_length <= XAW'(tile) * WORD_BYTES;
          go          <= 1'b1;
          addr        <= addr + XAW'(tile) * WORD_BYTES;
          remaining   <= remaining - tile;
          push_rem    <= tile;
          done_seen   <= 1'b0;
          state       <= STREAM;
        end
        STREAM: begin
          // The read master may report completion while words are still buffered.
          if (bus.rmst_done) done_seen <= 1'b1;
          if (push && push_rem == CW'(1)) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_seen || bus.rmst_done) begin
            done_seen <= 1'b0;
            state     <= (remaining != '0) ? ISSUE : FINISH;
          end
        end
        FINISH: begin
          load_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rmst_to_fifo_tile_mc.sv
// Directed bench with a read-master model and scoreboards for pushes and go commands.
module tb_rmst_to_fifo_tile_mc;
  localparam int AW = 12, XAW = 32, DW = 32, XDW = 128, CH = 4, TILE_XW = 8;
  localparam int CHW = 2, WCNT = XDW / DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rmst_to_fifo_tile_mc_if #(.AW(AW), .XAW(XAW), .DW(DW), .XDW(XDW), .CH(CH)) bus ();

  rmst_to_fifo_tile_mc #(
    .AW(AW), .XAW(XAW), .DW(DW), .XDW(XDW), .CH(CH), .TILE_XW(TILE_XW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed { logic [CH-1:0] push; logic [DW-1:0] data; } push_t;
  typedef struct packed { logic [XAW-1:0] base; logic [XAW-1:0] len; } go_t;

  push_t          exp_push[$];
  go_t            exp_go[$];
  logic [XDW-1:0] rq[$];

  int compared = 0;
  int mismatched = 0;
  int push_count = 0;
  int done_pulses = 0;
  int pushes_at_done = 0;
  int last_ch = -1;
  bit flush = 1'b0;
  bit done_late = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] f(input logic [XAW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [XDW-1:0] mk_word(input logic [XAW-1:0] a);
    logic [XDW-1:0] w;
    w = '0;
    for (int i = 0; i < WCNT; i++) w[i*DW +: DW] = f(a + XAW'(4 * i));
    return w;
  endfunction

  function automatic logic [127:0] out_vec();
    return 128'({bus.rmst_go, bus.rmst_user_read_buffer, bus.fifo_push, bus.load_data_done,
                 bus.rmst_read_base, bus.rmst_read_length, bus.rmst_data_in,
                 bus.rmst_fixed_location});
  endfunction

  // Read-master model: fills its show-ahead buffer on go, then reports done.
  initial begin
    bit rd, go, pend;
    int dly;
    logic [XAW-1:0] gb, gl;
    pend = 1'b0; dly = -1; gb = '0; gl = '0;
    forever begin
      @(negedge clk);
      rd = bus.rmst_user_read_buffer;
      go = bus.rmst_go;
      if (go) begin
        gb = bus.rmst_read_base;
        gl = bus.rmst_read_length;
      end
      if (rd) check("pop_has_data", 128'(rq.size() > 0), 128'(1));
      if (bus.rmst_done) begin
        check("base_stable", 128'(bus.rmst_read_base), 128'(gb));
        check("length_stable", 128'(bus.rmst_read_length), 128'(gl));
      end
      @(posedge clk);
      #1;
      bus.rmst_done = 1'b0;
      if (flush) begin
        rq.delete();
        pend = 1'b0;
        dly = -1;
      end else begin
        if (rd && rq.size() > 0) void'(rq.pop_front());
        if (go) begin
          for (int w = 0; w < int'(gl / 16); w++) rq.push_back(mk_word(gb + XAW'(16 * w)));
          pend = 1'b1;
          dly = done_late ? -1 : 2;
        end else if (pend) begin
          if (dly < 0) begin
            if (rq.size() == 0) dly = 8;
          end else if (dly > 0) begin
            dly--;
          end
          if (dly == 0) begin
            bus.rmst_done = 1'b1;
            pend = 1'b0;
            dly = -1;
          end
        end
      end
      bus.rmst_user_data_available = (rq.size() > 0);
      bus.rmst_user_buffer_data = (rq.size() > 0) ? rq[0] : '0;
    end
  end

  // Output monitor: scoreboards pushes and go commands, counts done pulses.
  initial begin
    push_t e;
    go_t g;
    forever begin
      @(negedge clk);
      if (bus.fifo_push !== '0) begin
        push_count++;
        check("push_vs_almost_full", 128'(bus.fifo_push & bus.fifo_almost_full), 128'(0));
        check("push_expected", 128'(exp_push.size() > 0), 128'(1));
        if (exp_push.size() > 0) begin
          e = exp_push.pop_front();
          check("push_word", 128'({bus.fifo_push, bus.rmst_data_in}), 128'(e));
        end
        for (int c = 0; c < CH; c++) if (bus.fifo_push[c]) last_ch = c;
      end
      if (bus.rmst_go) begin
        check("go_expected", 128'(exp_go.size() > 0), 128'(1));
        if (exp_go.size() > 0) begin
          g = exp_go.pop_front();
          check("go_cmd", 128'({bus.rmst_read_base, bus.rmst_read_length}), 128'(g));
        end
      end
      if (bus.load_data_done) begin
        done_pulses++;
        pushes_at_done = push_count;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_job(input logic [XAW-1:0] raddr, input int iolen, input bit mode,
                         input int ch, input bit late);
    push_t e;
    go_t g;
    int rem, t;
    logic [XAW-1:0] a;
    done_late = late;
    for (int k = 0; k < iolen; k++) begin
      e.push = CH'(1) << (mode ? ch : k % CH);
      e.data = f(raddr + XAW'(4 * k));
      exp_push.push_back(e);
    end
    rem = iolen;
    a = raddr;
    while (rem > 0) begin
      t = (rem < TILE_XW * WCNT) ? rem : TILE_XW * WCNT;
      g.base = a;
      g.len = XAW'(t * 4);
      exp_go.push_back(g);
      a = a + XAW'(t * 4);
      rem = rem - t;
    end
    @(posedge clk);
    #1;
    bus.param_raddr = raddr;
    bus.param_iolen = AW'(iolen);
    bus.param_mode = mode;
    bus.param_ch = CHW'(ch);
    bus.load_data_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_data_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int dp0);
    int n;
    n = 0;
    while (done_pulses == dp0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(done_pulses > dp0), 128'(1));
  endtask

  task automatic finish_job(input string tag, input int n, input int pc0, input int dp0);
    repeat (4) @(negedge clk);
    check({tag, "_done_count"}, 128'(done_pulses - dp0), 128'(1));
    check({tag, "_push_total"}, 128'(push_count - pc0), 128'(n));
    check({tag, "_push_queue_empty"}, 128'(exp_push.size()), 128'(0));
    check({tag, "_go_queue_empty"}, 128'(exp_go.size()), 128'(0));
  endtask

  initial begin
    int pc0, dp0, n;
    bus.load_data_start = 1'b0;
    bus.param_raddr = '0;
    bus.param_iolen = '0;
    bus.param_mode = 1'b0;
    bus.param_ch = '0;
    bus.rmst_done = 1'b0;
    bus.rmst_user_buffer_data = '0;
    bus.rmst_user_data_available = 1'b0;
    bus.fifo_almost_full = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Two full tiles, late done, with a start pulse mid-job that must be ignored.
    pc0 = push_count; dp0 = done_pulses;
    run_job(32'h1000, 64, 1'b0, 0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    bus.param_raddr = 32'h9000;
    bus.param_iolen = AW'(8);
    bus.load_data_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_data_start = 1'b0;
    wait_done("job64_done", dp0);
    finish_job("job64", 64, pc0, dp0);

    // Full tile followed by a short one.
    pc0 = push_count; dp0 = done_pulses;
    run_job(32'h2000, 40, 1'b0, 0, 1'b0);
    wait_done("job40_done", dp0);
    finish_job("job40", 40, pc0, dp0);
    check("job40_last_channel", 128'(last_ch), 128'(3));

    // Backpressure on channel 2 for 10 cycles; channel 0 almost_full must not matter.
    pc0 = push_count; dp0 = done_pulses;
    run_job(32'h3000, 64, 1'b0, 0, 1'b0);
    n = 0;
    while (!((push_count - pc0) >= 20 && bus.fifo_push == 4'b0010) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("stall_reached", 128'(n < 2000), 128'(1));
    @(posedge clk);
    #1;
    bus.fifo_almost_full = 4'b0101;
    n = push_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_no_push", 128'(bus.fifo_push), 128'(0));
    end
    check("stall_push_count", 128'(push_count), 128'(n));
    @(posedge clk);
    #1;
    bus.fifo_almost_full = '0;
    wait_done("stall_done", dp0);
    finish_job("stall", 64, pc0, dp0);

    // Zero-length job: no go, done exactly two cycles after start.
    dp0 = done_pulses;
    @(posedge clk);
    #1;
    bus.param_raddr = 32'h7000;
    bus.param_iolen = '0;
    bus.param_mode = 1'b0;
    bus.load_data_start = 1'b1;
    @(negedge clk);
    check("zero_done_c0", 128'(bus.load_data_done), 128'(0));
    @(posedge clk);
    #1;
    bus.load_data_start = 1'b0;
    @(negedge clk);
    check("zero_done_c1", 128'(bus.load_data_done), 128'(0));
    @(negedge clk);
    check("zero_done_c2", 128'(bus.load_data_done), 128'(1));
    @(negedge clk);
    check("zero_done_c3", 128'(bus.load_data_done), 128'(0));
    finish_job("zero", 0, push_count, dp0);

    // Single-channel mode, early done, other channels held almost full.
    pc0 = push_count; dp0 = done_pulses;
    bus.fifo_almost_full = 4'b0111;
    run_job(32'h4000, 16, 1'b1, 3, 1'b0);
    wait_done("mode1_done", dp0);
    check("mode1_done_after_last_push", 128'(pushes_at_done - pc0), 128'(16));
    bus.fifo_almost_full = '0;
    finish_job("mode1", 16, pc0, dp0);

    // Reset in the middle of streaming, then a fresh short job.
    pc0 = push_count;
    run_job(32'h5000, 64, 1'b0, 0, 1'b1);
    n = 0;
    while ((push_count - pc0) < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reset_reached_stream", 128'(n < 2000), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    exp_push.delete();
    exp_go.delete();
    @(negedge clk);
    check("midrun_reset_outputs", out_vec(), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    flush = 1'b0;
    pc0 = push_count; dp0 = done_pulses;
    run_job(32'h6000, 8, 1'b0, 0, 1'b0);
    wait_done("post_reset_done", dp0);
    finish_job("post_reset", 8, pc0, dp0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
